// File: rtl/adder_operand_pairer_fifo_seq.sv
// fifo_seq: synchronous single-clock FIFO with registered count and full/empty flags.
module fifo_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [DATA_WIDTH-1:0]         head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign full    = count == CW'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/adder_operand_pairer.sv
// adder_operand_pairer: buffers two operand lanes and emits registered aligned pairs to the adder.
module adder_operand_pairer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              i_valid,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    output logic [1:0]              o_ready,
    output logic [1:0]              o_valid,
    output logic [2*DATA_WIDTH-1:0] o_data_bus,
    input  logic                    i_en,
    output logic                    o_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [1:0] push, full, empty;
    logic pop;
    logic [DATA_WIDTH-1:0] head [2];
    logic [CW-1:0] count [2];
    assign push = {2{i_en}} & i_valid & o_ready;
    assign pop  = i_en & ~|empty;
    for (genvar k = 0; k < 2; k++) begin : g_lane
        fifo_seq #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop),
            .din   (i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]),
            .head  (head[k]),
            .count (count[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
        // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
        assign o_ready[k] = count[k] < CW'(FIFO_DEPTH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= '0;
            o_data_bus <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_valid    <= {2{pop}};
            o_data_bus <= pop ? {head[1], head[0]} : '0;
            o_overflow <= o_overflow | (i_en & |(i_valid & full));
        end
    end
endmodule

// File: tb/tb_adder_operand_pairer.sv
// tb_adder_operand_pairer: directed stimulus, queue-based reference model and literal expectations.
module tb_adder_operand_pairer;
    logic clk = 1'b0;
    logic rst, i_en, o_overflow;
    logic [1:0] i_valid, o_ready, o_valid;
    logic [31:0] i_data_bus, o_data_bus;
    int checks = 0, failures = 0, beats;
    bit cmp_on = 0;
    logic [15:0] qa[$], qb[$];
    logic [1:0] ev;
    logic [31:0] ed;
    logic eovf;

    adder_operand_pairer #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .o_ready(o_ready),
        .o_valid(o_valid), .o_data_bus(o_data_bus), .i_en(i_en), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per-lane queues, pairs taken from the fronts before this cycle's pushes.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete(); qb.delete();
            ev = 2'b00; ed = '0; eovf = 1'b0;
        end else begin
            logic ra, rb;
            ev = 2'b00; ed = '0;
            if (i_en) begin
                ra = qa.size() < 4;
                rb = qb.size() < 4;
                if (qa.size() > 0 && qb.size() > 0) begin
                    ev = 2'b11;
                    ed = {qa.pop_front(), qb.pop_front()};
                end
                if (i_valid[1]) begin
                    if (ra) qa.push_back(i_data_bus[31:16]); else eovf = 1'b1;
                end
                if (i_valid[0]) begin
                    if (rb) qb.push_back(i_data_bus[15:0]); else eovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_valid", 64'(o_valid), 64'(ev));
            chk("model_data", 64'(o_data_bus), 64'(ed));
            chk("model_ready", 64'(o_ready), 64'({qa.size() < 4, qb.size() < 4}));
            chk("model_overflow", 64'(o_overflow), 64'(eovf));
        end
    end

    task automatic tick(input logic r, input logic en, input logic [1:0] v, input logic [15:0] a, input logic [15:0] b);
        rst = r; i_en = en; i_valid = v; i_data_bus = {a, b};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        tick(1, 0, 2'b00, 0, 0);
    endtask

    initial begin
        tick(1, 1, 2'b11, 16'hffff, 16'hffff);
        do_reset();
        cmp_on = 1;
        chk("reset_valid", 64'(o_valid), 64'h0);
        chk("reset_ready", 64'(o_ready), 64'h3);
        chk("reset_ovf", 64'(o_overflow), 64'h0);

        // aligned pair
        tick(0, 1, 2'b11, 16'h0003, 16'h0005);
        chk("aligned_c1_valid", 64'(o_valid), 64'h0);
        idle(1);
        chk("aligned_c2_valid", 64'(o_valid), 64'h3);
        chk("aligned_c2_data", 64'(o_data_bus), 64'h0003_0005);
        idle(1);
        chk("aligned_c3_valid", 64'(o_valid), 64'h0);
        chk("aligned_c3_data", 64'(o_data_bus), 64'h0);

        // skewed arrival
        do_reset();
        tick(0, 1, 2'b10, 16'h0010, 0);
        for (int i = 0; i < 5; i++) begin
            chk("skew_wait_valid", 64'(o_valid), 64'h0);
            idle(1);
        end
        tick(0, 1, 2'b01, 0, 16'h0020);
        chk("skew_c6_valid", 64'(o_valid), 64'h0);
        idle(1);
        chk("skew_c7_valid", 64'(o_valid), 64'h3);
        chk("skew_c7_data", 64'(o_data_bus), 64'h0010_0020);
        idle(1);
        chk("skew_c8_valid", 64'(o_valid), 64'h0);

        // ordering and full
        do_reset();
        for (int i = 1; i <= 4; i++) tick(0, 1, 2'b10, 16'(i), 0);
        chk("full_ready", 64'(o_ready), 64'h1);
        tick(0, 1, 2'b10, 16'd5, 0);
        chk("full_ovf", 64'(o_overflow), 64'h1);
        tick(0, 1, 2'b01, 0, 16'd9);
        chk("ord_valid0", 64'(o_valid), 64'h0);
        tick(0, 1, 2'b01, 0, 16'd8);
        chk("ord_pair1", 64'(o_data_bus), 64'h0001_0009);
        tick(0, 1, 2'b01, 0, 16'd7);
        chk("ord_pair2", 64'(o_data_bus), 64'h0002_0008);
        tick(0, 1, 2'b01, 0, 16'd6);
        chk("ord_pair3", 64'(o_data_bus), 64'h0003_0007);
        idle(1);
        chk("ord_pair4", 64'(o_data_bus), 64'h0004_0006);
        idle(1);
        chk("ord_end_valid", 64'(o_valid), 64'h0);
        chk("ord_ovf_sticky", 64'(o_overflow), 64'h1);

        // streaming
        do_reset();
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 2'b11, 16'(i), 16'(100 + i));
            if (o_valid == 2'b11) beats++;
            chk("stream_ready", 64'(o_ready), 64'h3);
            if (i == 1) chk("stream_first", 64'(o_data_bus), 64'h0000_0064);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (o_valid == 2'b11) beats++;
        end
        chk("stream_beats", 64'(beats), 64'd10);

        // enable gating
        do_reset();
        tick(0, 1, 2'b10, 16'h0011, 0);
        tick(0, 1, 2'b10, 16'h0033, 0);
        tick(0, 1, 2'b01, 0, 16'h0022);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 2'b11, 16'hdead, 16'hbeef);
            chk("en_off_valid", 64'(o_valid), 64'h0);
            chk("en_off_ovf", 64'(o_overflow), 64'h0);
        end
        tick(0, 1, 2'b01, 0, 16'h0044);
        chk("en_on_pair1", 64'(o_data_bus), 64'h0011_0022);
        idle(1);
        chk("en_on_pair2", 64'(o_data_bus), 64'h0033_0044);
        idle(1);
        chk("en_on_done", 64'(o_valid), 64'h0);

        // reset mid-operation, including a reset during a cycle that would pop
        for (int i = 0; i < 5; i++) tick(0, 1, 2'b10, 16'(i + 1), 0);
        tick(0, 1, 2'b01, 0, 16'h0077);
        tick(1, 0, 2'b00, 0, 0);
        chk("rst_mid_valid", 64'(o_valid), 64'h0);
        chk("rst_mid_data", 64'(o_data_bus), 64'h0);
        chk("rst_mid_ready", 64'(o_ready), 64'h3);
        chk("rst_mid_ovf", 64'(o_overflow), 64'h0);
        tick(0, 1, 2'b01, 0, 16'h0099);
        idle(2);
        chk("rst_no_stale", 64'(o_valid), 64'h0);
        tick(0, 1, 2'b10, 16'h0055, 0);
        idle(1);
        chk("rst_after_pair", 64'(o_data_bus), 64'h0055_0099);
        idle(1);
        cmp_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
